mem_arbiter: RTL and testbench
==============================

# mem_arbiter

- Sequences the single byte-serial memory controller between three requesters: load/store buffer (LS), instruction fetch (IF) and instruction prefetch (PF).
- Holds one transaction in flight at a time and forwards its operands to the controller.
- Routes the controller's completion back to the owner of the transaction.
- Discards instruction reads cancelled by a pipeline flush.

## Interface
Parameters:
- AGE_LIMIT, 4: consecutive LS grants tolerated while IF waits (used only with aging; range 1–15).
- ADDR_W, 32: address width.
- DATA_W, 32: data/instruction width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; low freezes all state.
- flush  in  1  branch redirect; cancels IF/PF work.
- ls_req  in  1  LS request; held with operands until ls_done.
- ls_ls  in  1  0 = load, 1 = store.
- ls_len  in  3  byte count: 1, 2 or 4.
- ls_addr  in  ADDR_W  byte address.
- ls_wdata  in  DATA_W  store data.
- ls_done  out  1  one-cycle completion pulse.
- ls_rdata  out  DATA_W  load data, valid with ls_done.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch PC.
- if_done  out  1  fetch completion pulse.
- if_inst  out  DATA_W  instruction, valid with if_done.
- pf_req  in  1  prefetch request.
- pf_addr  in  ADDR_W  prefetch PC.
- pf_done  out  1  prefetch completion pulse.
- pf_inst  out  DATA_W  instruction, valid with pf_done.
- mc_en  out  1  transaction valid to the controller; held until mc_done.
- mc_ls  out  1  0 = read, 1 = write.
- mc_len  out  3  byte count; 4 for instruction reads.
- mc_addr  out  ADDR_W  transaction address.
- mc_wdata  out  DATA_W  write data.
- mc_done  in  1  controller completion pulse.
- mc_rdata  in  DATA_W  read data, valid with mc_done.

## Operation
- States: IDLE, BUSY_LS, BUSY_IF, BUSY_PF, DRAIN.
- IDLE: arbitration on registered requests, priority LS > IF > PF.
  - Winner's operands are latched into internal registers.
  - State moves to BUSY_x.
  - No request: stay in IDLE.
  - flush high in IDLE: if_req and pf_req are ignored that cycle; LS may still win.
- BUSY_x:
  - mc_en = 1 and mc_* come from the latched registers (stable for the whole transaction).
  - When mc_done = 1: x_done = 1 combinationally and x_rdata/x_inst = mc_rdata in the same cycle. Next state is IDLE.
- flush while in BUSY_IF or BUSY_PF with mc_done = 0: go to DRAIN.
  - The controller cannot abort, so mc_en and operands stay held.
- DRAIN: on mc_done, no *_done is issued, data is discarded, next state is IDLE.
- flush coinciding with mc_done in BUSY_IF/PF: done is suppressed and next state is IDLE, not DRAIN.
- BUSY_LS is never affected by flush; loads and stores always complete.
- Unused response data outputs are 0 whenever their done is 0.
- Load data is passed through unmodified; the controller zero-extends it.
- rdy = 0: state, latches and age counter hold. Outputs follow the held state. mc_done is ignored while rdy = 0.
- rst: state goes to IDLE; latches and counter are cleared.
- Reset values: all *_done, mc_en and mc_ls are 0; all data and address outputs are 0.

## Timing
- Request sampled in IDLE at edge t: mc_en is high in cycle t+1. Arbitration latency is one cycle.
- mc_done in cycle n: requester done in cycle n; state is IDLE in cycle n+1.
  - Earliest next mc_en is n+2, giving one idle bubble between transactions.
- Requester must keep req high until its done.
  - Dropping req while BUSY is not a cancel; the done still fires.
- Flush takes effect in the cycle it is asserted; no IF/PF done is issued in that cycle or afterwards for cancelled work.

## Configuration
- ARB_AGING_EN defined:
  - A 4-bit age counter increments on each LS grant made while if_req = 1.
  - When the counter equals AGE_LIMIT, the next arbitration gives IF priority over LS.
  - The counter clears on any IF grant, whenever if_req = 0 in IDLE, and on flush.
- ARB_AGING_EN undefined: fixed LS > IF > PF priority; no counter logic.

## Test plan
- Fetch: if_req, if_addr = 0x100; mc_done with mc_rdata = 0x00A00093 four cycles later.
  - Required: mc_en at t+1 with mc_len = 4 and mc_addr = 0x100; if_done with if_inst = 0x00A00093 in the mc_done cycle; IDLE next cycle.
- Conflict: ls_req store (len 2, addr 0x1000, wdata 0xBEEF) and if_req in the same cycle.
  - Required: store issued first with mc_ls = 1; fetch issued at mc_done+2.
- Flush drain: flush two cycles into BUSY_IF.
  - Required: mc_en stays 1 until mc_done; if_done never pulses; IDLE afterward.
- Flush at mc_done: flush and mc_done in the same BUSY_PF cycle.
  - Required: pf_done = 0; next state IDLE.
- Stall and reset: rdy = 0 for 3 cycles mid-BUSY_LS.
  - Required: outputs frozen; completion after rdy returns.
  - rst mid-transaction: all outputs 0 in the next cycle.
- Aging (ARB_AGING_EN, AGE_LIMIT = 2): continuous ls_req with if_req held.
  - Required: the third grant goes to IF.
  - Without the macro: IF is never granted while ls_req is held.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: the arbiter's requester and controller signals.
//
// Handshake rules:
//   - Each requester raises x_req with its operands and holds both until it
//     sees x_done, a one-cycle pulse that carries x_rdata/x_inst.
//   - The arbiter raises mc_en with its operands and holds both until the
//     controller returns mc_done, a one-cycle pulse that carries mc_rdata.
//
// Modports:
//   slave  - the arbiter's view (requests and mc_done in; dones and mc_* out)
//   master - the environment's view (requesters plus memory controller)
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ls_req;
  logic              ls_ls;
  logic [2:0]        ls_len;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_done;
  logic [DATA_W-1:0] ls_rdata;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_inst;

  logic              pf_req;
  logic [ADDR_W-1:0] pf_addr;
  logic              pf_done;
  logic [DATA_W-1:0] pf_inst;

  logic              mc_en;
  logic              mc_ls;
  logic [2:0]        mc_len;
  logic [ADDR_W-1:0] mc_addr;
  logic [DATA_W-1:0] mc_wdata;
  logic              mc_done;
  logic [DATA_W-1:0] mc_rdata;

  modport slave (
    input  ls_req, ls_ls, ls_len, ls_addr, ls_wdata,
    input  if_req, if_addr, pf_req, pf_addr,
    input  mc_done, mc_rdata,
    output ls_done, ls_rdata, if_done, if_inst, pf_done, pf_inst,
    output mc_en, mc_ls, mc_len, mc_addr, mc_wdata
  );

  modport master (
    output ls_req, ls_ls, ls_len, ls_addr, ls_wdata,
    output if_req, if_addr, pf_req, pf_addr,
    output mc_done, mc_rdata,
    input  ls_done, ls_rdata, if_done, if_inst, pf_done, pf_inst,
    input  mc_en, mc_ls, mc_len, mc_addr, mc_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-serial memory controller between the
// load/store buffer (LS), instruction fetch (IF) and prefetch (PF).
// One transaction is in flight at a time; its operands are latched at grant
// and held on mc_* until mc_done, whose data is routed back to the owner.
// A flush cancels IF/PF work: the controller cannot abort, so a cancelled
// read is drained silently.
//
// Ports:
//   clk, rst   - clock; synchronous active-high reset
//   rdy        - global enable; low freezes state, latches and age counter
//   flush      - branch redirect; cancels IF/PF work
//   bus        - mem_arbiter_if.slave: requester and controller signals
//   state_dbg  - current FSM state (IDLE=0, BUSY_LS=1, BUSY_IF=2,
//                BUSY_PF=3, DRAIN=4)
//
// Optional feature: define ARB_AGING_EN to let IF overtake LS after
// AGE_LIMIT consecutive LS grants made while IF was waiting.
module mem_arbiter #(
  parameter int AGE_LIMIT = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         flush,
  mem_arbiter_if.slave bus,
  output logic [2:0]   state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY_LS = 3'd1,
    BUSY_IF = 3'd2,
    BUSY_PF = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  state_t state, state_nx;

  logic              lat_ls;
  logic [2:0]        lat_len;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic grant_ls, grant_if, grant_pf;
  logic if_aged;
  logic done_take;

  // mc_done only counts while enabled.
  assign done_take = rdy & bus.mc_done;
  assign state_dbg = state;

`ifdef ARB_AGING_EN
  logic [3:0] age;

  assign if_aged = (age == 4'(AGE_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      age <= 4'd0;
    end else if (rdy) begin
      if (flush) begin
        age <= 4'd0;
      end else if (state == IDLE) begin
        if (!bus.if_req || grant_if) age <= 4'd0;
        else if (grant_ls)           age <= age + 4'd1;
      end
    end
  end
`else
  assign if_aged = 1'b0;
`endif

  // Arbitration in IDLE. A flush in the same cycle hides IF/PF requests.
  always_comb begin
    grant_ls = 1'b0;
    grant_if = 1'b0;
    grant_pf = 1'b0;
    if (state == IDLE && rdy) begin
      if (if_aged && bus.if_req && !flush) grant_if = 1'b1;
      else if (bus.ls_req)                 grant_ls = 1'b1;
      else if (bus.if_req && !flush)       grant_if = 1'b1;
      else if (bus.pf_req && !flush)       grant_pf = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (grant_ls)      state_nx = BUSY_LS;
        else if (grant_if) state_nx = BUSY_IF;
        else if (grant_pf) state_nx = BUSY_PF;
      end
      BUSY_LS: if (done_take) state_nx = IDLE;
      BUSY_IF, BUSY_PF: begin
        // A flush landing with mc_done needs no drain: the read is over.
        if (done_take)         state_nx = IDLE;
        else if (rdy && flush) state_nx = DRAIN;
      end
      DRAIN: if (done_take) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs: operands come only from the latches; responses are zero
  // unless their done pulses.
  always_comb begin
    bus.mc_en    = 1'b0;
    bus.mc_ls    = 1'b0;
    bus.mc_len   = 3'd0;
    bus.mc_addr  = '0;
    bus.mc_wdata = '0;
    bus.ls_done  = 1'b0;
    bus.ls_rdata = '0;
    bus.if_done  = 1'b0;
    bus.if_inst  = '0;
    bus.pf_done  = 1'b0;
    bus.pf_inst  = '0;
    if (state != IDLE) begin
      bus.mc_en    = 1'b1;
      bus.mc_ls    = lat_ls;
      bus.mc_len   = lat_len;
      bus.mc_addr  = lat_addr;
      bus.mc_wdata = lat_wdata;
    end
    case (state)
      BUSY_LS: if (done_take) begin
        bus.ls_done  = 1'b1;
        bus.ls_rdata = bus.mc_rdata;
      end
      BUSY_IF: if (done_take && !flush) begin
        bus.if_done = 1'b1;
        bus.if_inst = bus.mc_rdata;
      end
      BUSY_PF: if (done_take && !flush) begin
        bus.pf_done = 1'b1;
        bus.pf_inst = bus.mc_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_ls    <= 1'b0;
      lat_len   <= 3'd0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (rdy) begin
      state <= state_nx;
      if (grant_ls) begin
        lat_ls    <= bus.ls_ls;
        lat_len   <= bus.ls_len;
        lat_addr  <= bus.ls_addr;
        lat_wdata <= bus.ls_wdata;
      end else if (grant_if) begin
        lat_ls    <= 1'b0;
        lat_len   <= 3'd4;
        lat_addr  <= bus.if_addr;
        lat_wdata <= '0;
      end else if (grant_pf) begin
        lat_ls    <= 1'b0;
        lat_len   <= 3'd4;
        lat_addr  <= bus.pf_addr;
        lat_wdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios with literal expectations, then
// randomized requesters and controller, all checked every cycle against a
// transaction-level model of the arbiter.
module tb_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int AGE = 2;

  localparam logic [1:0] OWN_LS = 2'd0;
  localparam logic [1:0] OWN_IF = 2'd1;
  localparam logic [1:0] OWN_PF = 2'd2;

  typedef struct packed {
    logic [1:0]    owner;
    logic          cancelled;
    logic          ls;
    logic [2:0]    len;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst, rdy, flush;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.AGE_LIMIT(AGE), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .flush     (flush),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  txn_t exp_q[$];   // the transaction in flight, if any
  int   m_age = 0;
  bit   seen_ls_done, seen_if_done, seen_pf_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an in-flight transaction record plus the arbitration rules.
  always @(negedge clk) begin : model_chk
    txn_t cur, t;
    bit   has, fire, aged;
    int   win;
    if (chk_en) begin
      has  = exp_q.size() != 0;
      cur  = has ? exp_q[0] : '0;
      fire = has && rdy && bus.mc_done && !cur.cancelled &&
             !(cur.owner != OWN_LS && flush);
      chk("mc_en",    64'(bus.mc_en),    64'(has));
      chk("mc_ls",    64'(bus.mc_ls),    64'(cur.ls));
      chk("mc_len",   64'(bus.mc_len),   64'(cur.len));
      chk("mc_addr",  64'(bus.mc_addr),  64'(cur.addr));
      chk("mc_wdata", 64'(bus.mc_wdata), 64'(cur.wdata));
      chk("ls_done",  64'(bus.ls_done),  64'(fire && cur.owner == OWN_LS));
      chk("ls_rdata", 64'(bus.ls_rdata), (fire && cur.owner == OWN_LS) ? 64'(bus.mc_rdata) : 64'd0);
      chk("if_done",  64'(bus.if_done),  64'(fire && cur.owner == OWN_IF));
      chk("if_inst",  64'(bus.if_inst),  (fire && cur.owner == OWN_IF) ? 64'(bus.mc_rdata) : 64'd0);
      chk("pf_done",  64'(bus.pf_done),  64'(fire && cur.owner == OWN_PF));
      chk("pf_inst",  64'(bus.pf_inst),  (fire && cur.owner == OWN_PF) ? 64'(bus.mc_rdata) : 64'd0);

      if (rst) begin
        exp_q.delete();
        m_age = 0;
      end else if (rdy) begin
        if (!has) begin
`ifdef ARB_AGING_EN
          aged = (m_age == AGE) && bus.if_req && !flush;
`else
          aged = 1'b0;
`endif
          win = -1;
          if (aged)                      win = 1;
          else if (bus.ls_req)           win = 0;
          else if (bus.if_req && !flush) win = 1;
          else if (bus.pf_req && !flush) win = 2;
          if (flush || !bus.if_req || win == 1) m_age = 0;
          else if (win == 0)                    m_age = m_age + 1;
          t = '0;
          if (win == 0) begin
            t.owner = OWN_LS; t.ls = bus.ls_ls; t.len = bus.ls_len;
            t.addr = bus.ls_addr; t.wdata = bus.ls_wdata;
          end else if (win == 1) begin
            t.owner = OWN_IF; t.len = 3'd4; t.addr = bus.if_addr;
          end else if (win == 2) begin
            t.owner = OWN_PF; t.len = 3'd4; t.addr = bus.pf_addr;
          end
          if (win >= 0) exp_q.push_back(t);
        end else begin
          if (flush) m_age = 0;
          if (bus.mc_done) begin
            void'(exp_q.pop_front());
          end else if (flush && cur.owner != OWN_LS) begin
            t = exp_q.pop_front();
            t.cancelled = 1'b1;
            exp_q.push_front(t);
          end
        end
      end
    end
    seen_ls_done = bus.ls_done;
    seen_if_done = bus.if_done;
    seen_pf_done = bus.pf_done;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ls_ops();
    bus.ls_ls    = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 2))
      0:       bus.ls_len = 3'd1;
      1:       bus.ls_len = 3'd2;
      default: bus.ls_len = 3'd4;
    endcase
    bus.ls_addr  = $urandom;
    bus.ls_wdata = $urandom;
  endtask

  task automatic clear_inputs();
    bus.ls_req = 0; bus.ls_ls = 0; bus.ls_len = 0; bus.ls_addr = 0; bus.ls_wdata = 0;
    bus.if_req = 0; bus.if_addr = 0; bus.pf_req = 0; bus.pf_addr = 0;
    bus.mc_done = 0; bus.mc_rdata = 0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [AW-1:0] grant_addr [3];
    int cnt;
    bit pflush;

    clear_inputs();
    rst = 1; rdy = 1; flush = 0;
    step();
    chk_en = 1;
    @(negedge clk);
    chk("reset_mc_en",   64'(bus.mc_en), 64'd0);
    chk("reset_mc_addr", 64'(bus.mc_addr), 64'd0);
    chk("reset_ls_done", 64'(bus.ls_done), 64'd0);

    // Fetch.
    step();
    rst = 0; bus.if_req = 1; bus.if_addr = 32'h100;
    step();
    @(negedge clk);
    chk("fetch_mc_en",   64'(bus.mc_en), 64'd1);
    chk("fetch_mc_len",  64'(bus.mc_len), 64'd4);
    chk("fetch_mc_addr", 64'(bus.mc_addr), 64'h100);
    step(); step(); step();
    bus.mc_done = 1; bus.mc_rdata = 32'h00A00093;
    @(negedge clk);
    chk("fetch_if_done", 64'(bus.if_done), 64'd1);
    chk("fetch_if_inst", 64'(bus.if_inst), 64'h00A00093);
    step();
    bus.mc_done = 0; bus.mc_rdata = 0; bus.if_req = 0;
    @(negedge clk);
    chk("fetch_idle", 64'(bus.mc_en), 64'd0);

    // Store and fetch requested together.
    step();
    bus.ls_req = 1; bus.ls_ls = 1; bus.ls_len = 3'd2; bus.ls_addr = 32'h1000; bus.ls_wdata = 32'hBEEF;
    bus.if_req = 1; bus.if_addr = 32'h200;
    step();
    @(negedge clk);
    chk("conf_mc_ls",    64'(bus.mc_ls), 64'd1);
    chk("conf_mc_len",   64'(bus.mc_len), 64'd2);
    chk("conf_mc_addr",  64'(bus.mc_addr), 64'h1000);
    chk("conf_mc_wdata", 64'(bus.mc_wdata), 64'hBEEF);
    step();
    bus.mc_done = 1;
    @(negedge clk);
    chk("conf_ls_done", 64'(bus.ls_done), 64'd1);
    step();
    bus.mc_done = 0; bus.ls_req = 0;
    @(negedge clk);
    chk("conf_bubble", 64'(bus.mc_en), 64'd0);
    step();
    @(negedge clk);
    chk("conf_if_en",   64'(bus.mc_en), 64'd1);
    chk("conf_if_ls",   64'(bus.mc_ls), 64'd0);
    chk("conf_if_addr", 64'(bus.mc_addr), 64'h200);
    step();
    bus.mc_done = 1; bus.mc_rdata = 32'h13;
    @(negedge clk);
    chk("conf_if_inst", 64'(bus.if_inst), 64'h13);
    step();
    bus.mc_done = 0; bus.mc_rdata = 0; bus.if_req = 0;

    // Flush two cycles into a fetch: drain.
    step();
    bus.if_req = 1; bus.if_addr = 32'h300;
    step();
    step();
    flush = 1; bus.if_req = 0;
    @(negedge clk);
    chk("drain_flush_en", 64'(bus.mc_en), 64'd1);
    step();
    flush = 0;
    @(negedge clk);
    chk("drain_hold_en",   64'(bus.mc_en), 64'd1);
    chk("drain_hold_addr", 64'(bus.mc_addr), 64'h300);
    step();
    bus.mc_done = 1; bus.mc_rdata = 32'hDEAD;
    @(negedge clk);
    chk("drain_if_done", 64'(bus.if_done), 64'd0);
    chk("drain_if_inst", 64'(bus.if_inst), 64'd0);
    step();
    bus.mc_done = 0; bus.mc_rdata = 0;
    @(negedge clk);
    chk("drain_idle", 64'(bus.mc_en), 64'd0);

    // Flush coinciding with mc_done on a prefetch.
    step();
    bus.pf_req = 1; bus.pf_addr = 32'h400;
    step();
    @(negedge clk);
    chk("pf_mc_addr", 64'(bus.mc_addr), 64'h400);
    step();
    bus.mc_done = 1; bus.mc_rdata = 32'h55; flush = 1;
    @(negedge clk);
    chk("pf_flush_done", 64'(bus.pf_done), 64'd0);
    step();
    bus.mc_done = 0; bus.mc_rdata = 0; flush = 0; bus.pf_req = 0;
    @(negedge clk);
    chk("pf_flush_idle", 64'(bus.mc_en), 64'd0);

    // Stall a load for three cycles; an mc_done inside the stall is ignored.
    step();
    bus.ls_req = 1; bus.ls_ls = 0; bus.ls_len = 3'd4; bus.ls_addr = 32'h2000; bus.ls_wdata = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      rdy = 0; bus.mc_done = (i == 1);
      @(negedge clk);
      chk("stall_mc_en",   64'(bus.mc_en), 64'd1);
      chk("stall_addr",    64'(bus.mc_addr), 64'h2000);
      chk("stall_ls_done", 64'(bus.ls_done), 64'd0);
    end
    step();
    rdy = 1; bus.mc_done = 1; bus.mc_rdata = 32'hAB;
    @(negedge clk);
    chk("stall_done",  64'(bus.ls_done), 64'd1);
    chk("stall_rdata", 64'(bus.ls_rdata), 64'hAB);
    step();
    bus.mc_done = 0; bus.mc_rdata = 0; bus.ls_req = 0;

    // Reset in the middle of a store.
    step();
    bus.ls_req = 1; bus.ls_ls = 1; bus.ls_len = 3'd1; bus.ls_addr = 32'h44; bus.ls_wdata = 32'h77;
    step();
    step();
    rst = 1; bus.ls_req = 0;
    step();
    rst = 0;
    @(negedge clk);
    chk("rst_mc_en",    64'(bus.mc_en), 64'd0);
    chk("rst_mc_ls",    64'(bus.mc_ls), 64'd0);
    chk("rst_mc_addr",  64'(bus.mc_addr), 64'd0);
    chk("rst_mc_wdata", 64'(bus.mc_wdata), 64'd0);

    // LS held continuously with IF waiting.
    step();
    bus.ls_req = 1; bus.ls_ls = 0; bus.ls_len = 3'd4; bus.ls_addr = 32'h3000; bus.ls_wdata = 0;
    bus.if_req = 1; bus.if_addr = 32'h500;
    for (int g = 0; g < 3; g++) begin
      cnt = 0;
      do begin
        step();
        @(negedge clk);
        cnt++;
      end while (!bus.mc_en && cnt < 10);
      if (!bus.mc_en) chk("aging_grant_timeout", 64'd0, 64'd1);
      grant_addr[g] = bus.mc_addr;
      step();
      bus.mc_done = 1;
      step();
      bus.mc_done = 0;
    end
    bus.ls_req = 0; bus.if_req = 0;
    chk("aging_first", 64'(grant_addr[0]), 64'h3000);
`ifdef ARB_AGING_EN
    chk("aging_third", 64'(grant_addr[2]), 64'h500);
`else
    chk("aging_third", 64'(grant_addr[2]), 64'h3000);
`endif

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      step();
      pflush = flush;
      rst   = ($urandom_range(0, 499) == 0);
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 19) == 0);
      if (bus.ls_req) begin
        if (seen_ls_done) begin
          bus.ls_req = 1'($urandom_range(0, 1));
          rand_ls_ops();
        end
      end else if ($urandom_range(0, 2) == 0) begin
        bus.ls_req = 1;
        rand_ls_ops();
      end
      if (!bus.if_req || seen_if_done || pflush) begin
        bus.if_req  = 1'($urandom_range(0, 1));
        bus.if_addr = $urandom;
      end
      if (!bus.pf_req || seen_pf_done || pflush) begin
        bus.pf_req  = 1'($urandom_range(0, 1));
        bus.pf_addr = $urandom;
      end
      bus.mc_done  = bus.mc_en && ($urandom_range(0, 2) == 0);
      bus.mc_rdata = $urandom;
    end

    // Let any transaction in flight finish, then confirm the arbiter idles.
    step();
    rst = 0; rdy = 1; flush = 0;
    bus.ls_req = 0; bus.if_req = 0; bus.pf_req = 0;
    for (int c = 0; c < 20; c++) begin
      bus.mc_done  = bus.mc_en;
      bus.mc_rdata = $urandom;
      step();
    end
    bus.mc_done = 0;
    @(negedge clk);
    chk("final_idle", 64'(bus.mc_en), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
